ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage for the MIPS core; it produces the `Ins` word consumed by the decode/register-file stage. It owns the program counter, issues word reads to instruction memory over a request/acknowledge handshake, and holds each fetched instruction until decode accepts it. It accepts PC redirects from branch/jump resolution, flushing any held or in-flight instruction.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `Iaddr`  out  32  instruction memory word address (byte address, bits [1:0] = 0).
- `Ireq`  out  1  memory read request; held high with stable `Iaddr` until `Iack`.
- `Iack`  in  1  memory acknowledge; `Irdata` valid in the same cycle.
- `Irdata`  in  32  instruction word from memory.
- `Ins`  out  32  fetched instruction to decode.
- `InsPC`  out  32  address of `Ins`.
- `InsPC4`  out  32  `InsPC + 4`, used as the JAL link value.
- `InsValid`  out  1  `Ins`/`InsPC` valid.
- `InsReady`  in  1  decode accepts `Ins` this cycle.
- `Redirect`  in  1  single-cycle pulse: fetch from `RedirectPC` next.
- `RedirectPC`  in  32  redirect target, word-aligned.

## Operation

- State registers: `PC` (next fetch address), `PendPC`, FSM state.
- Reset values: `PC=RESET_PC`, state IDLE, `Ireq=0`, `Iaddr=RESET_PC`, `Ins=0`, `InsPC=0`, `InsPC4=4`, `InsValid=0`.
- All outputs are registered or decoded directly from the state.
- `Iaddr = PC` in REQ; `Iaddr` holds the outstanding address in DROP.
- States:
  - IDLE: outputs quiet; advance to REQ unconditionally on the next edge.
  - REQ: `Ireq=1`.
    - On `Iack`: capture `Ins<=Irdata`, `InsPC<=PC`, `InsPC4<=PC+4`, `PC<=NextPC`, then go to HOLD.
  - HOLD: `InsValid=1`, `Ireq=0`.
    - On `InsReady`: go to REQ.
  - DROP: `Ireq=1` at the stale address.
    - On `Iack`: discard `Irdata`, `PC<=PendPC`, then go to REQ.
- Default `NextPC = PC + 4`. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Redirect handling (redirect always has priority):
  - IDLE or HOLD: `PC<=RedirectPC`, `InsValid<=0`, go to REQ. A simultaneous `InsReady` in HOLD is ignored; the instruction is not consumed.
  - REQ without `Iack`: the request cannot be withdrawn. `PendPC<=RedirectPC`, go to DROP.
  - REQ with `Iack` in the same cycle: the returned word is discarded, `PC<=RedirectPC`, stay in REQ. The next cycle presents the new `Iaddr`.
  - DROP: `PendPC<=RedirectPC`. The newest redirect wins.
    - If `Iack` arrives in the same cycle, `PC<=RedirectPC` and go to REQ.
- Reset asserted mid-transaction: everything clears immediately. Memory must tolerate an abandoned request.
- `InsValid` never rises in the same cycle it is consumed.
- Each fetched word is presented exactly once unless flushed.

## Timing

- Zero-wait memory (`Iack` in the first REQ cycle):
  - Throughput is one instruction per 2 cycles: REQ, HOLD, REQ, ...
  - `Iack` to `InsValid` latency: 1 cycle.
- First `Ireq` rises 1 cycle after `RST` deasserts (IDLE → REQ).
- Redirect to new `Iaddr` on the bus:
  - 1 cycle from IDLE, HOLD, or REQ with `Iack`.
  - From REQ without `Iack` (via DROP): the stale ack cycle plus 1.
- `InsReady` is sampled only when `InsValid=1`.

## Configuration

- `IFETCH_PREDECODE_EN`
  - Defined: on `Iack` in REQ, if `Irdata[31:26]` is 6'h02 (J) or 6'h03 (JAL), then `NextPC = {PC4[31:28], Irdata[25:0], 2'b00}`, where PC4 = PC+4.
    - The jump instruction is still delivered to decode, so JAL can link.
    - An external `Redirect` still overrides.
  - Undefined: `NextPC = PC + 4` always; jumps rely on `Redirect`.

## Test plan

- Reset release with `RESET_PC`=32'h0040_0000, zero-wait memory returning 32'h2008_0005:
  - `Ireq` rises cycle 1 with `Iaddr`=32'h0040_0000.
  - `InsValid` rises cycle 2 with `Ins`=32'h2008_0005, `InsPC4`=32'h0040_0004.
  - Next `Iaddr`=32'h0040_0004.
- Decode backpressure: `InsReady=0` for 5 cycles.
  - `InsValid` stays 1 with `Ins` stable and `Ireq=0`.
  - Exactly one new request follows after `InsReady` pulses.
- Memory with 3 wait cycles, `Redirect` to 32'h0000_0100 in the first REQ cycle:
  - `Ireq` is held at the old address until `Iack`.
  - The returned word never appears on `Ins`.
  - Next `Iaddr`=32'h0000_0100.
- `Redirect` to 32'h0000_0200 in the same cycle as `InsReady` in HOLD:
  - `InsValid` drops.
  - Next `Iaddr`=32'h0000_0200.
- PC wrap: `Redirect` to 32'hFFFF_FFFC.
  - The following fetch address is 32'h0000_0000.
- With `IFETCH_PREDECODE_EN`, fetch 32'h0C00_0040 (JAL) at PC 32'h0040_0000:
  - `Ins` is delivered with `InsPC4`=32'h0040_0004.
  - Next `Iaddr`=32'h0000_0100.
- Without `IFETCH_PREDECODE_EN`, same fetch: next `Iaddr`=32'h0040_0004.
- Async reset asserted while in DROP:
  - All outputs return to reset values immediately.
  - A subsequent `Iack` is ignored.

Source files
------------

// File: rtl/ifetch.sv
// ifetch -- instruction fetch stage of the MIPS core.
//
// Owns the program counter and issues one word read at a time to
// instruction memory. Each fetched word is held on Ins/InsPC/InsPC4 until
// decode takes it. Branch/jump resolution can redirect the PC at any time.
// A redirect flushes the held instruction. It also marks an in-flight read
// as stale, and the stale read is dropped when its ack arrives.
//
// Optional feature: define IFETCH_PREDECODE_EN to follow J/JAL targets
// directly from the fetched word. Without it, the next PC is always PC + 4.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   Iaddr, Ireq         memory word address / read request (out)
//   Iack, Irdata        memory acknowledge / read data, same cycle (in)
//   Ins, InsPC, InsPC4  fetched instruction, its address, address + 4 (out)
//   InsValid, InsReady  instruction valid (out) / decode accepts (in)
//   Redirect, RedirectPC  single-cycle redirect pulse and target (in)
//   fsm_state           current FSM state, for observation (out)
//
// Handshakes:
//   Memory side: Ireq stays high and Iaddr stays stable until a cycle with
//   Iack=1. That cycle completes the transfer, and Irdata is sampled in it.
//   Decode side: a transfer happens on a cycle where InsValid=1 and
//   InsReady=1. InsReady is ignored while InsValid=0.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] Iaddr,
  output logic        Ireq,
  input  logic        Iack,
  input  logic [31:0] Irdata,
  output logic [31:0] Ins,
  output logic [31:0] InsPC,
  output logic [31:0] InsPC4,
  output logic        InsValid,
  input  logic        InsReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic [31:0] ins_pc4;
  logic [31:0] pc4;
  logic [31:0] next_pc;

  assign pc4 = pc + 32'd4;

`ifdef IFETCH_PREDECODE_EN
  // J (6'h02) and JAL (6'h03) are absolute within the current 256 MB
  // region, so the target is known as soon as the word is returned.
  always_comb begin
    next_pc = pc4;
    if (Irdata[31:26] == 6'h02 || Irdata[31:26] == 6'h03) begin
      next_pc = {pc4[31:28], Irdata[25:0], 2'b00};
    end
  end
`else
  assign next_pc = pc4;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      ins     <= 32'd0;
      ins_pc  <= 32'd0;
      ins_pc4 <= 32'd4;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (Redirect) pc <= RedirectPC;
        end
        REQ: begin
          if (Iack) begin
            if (Redirect) begin
              // The returned word belongs to the old stream. Drop it and
              // request the target on the very next cycle.
              pc <= RedirectPC;
            end else begin
              ins     <= Irdata;
              ins_pc  <= pc;
              ins_pc4 <= pc4;
              pc      <= next_pc;
              state   <= HOLD;
            end
          end else if (Redirect) begin
            // The request cannot be withdrawn. pc keeps the stale address
            // on the bus, and the target waits in pend_pc.
            pend_pc <= RedirectPC;
            state   <= DROP;
          end
        end
        HOLD: begin
          // A redirect beats a simultaneous InsReady, so the held word
          // is flushed and never consumed.
          if (Redirect) begin
            pc    <= RedirectPC;
            state <= REQ;
          end else if (InsReady) begin
            state <= REQ;
          end
        end
        DROP: begin
          if (Redirect) pend_pc <= RedirectPC;
          if (Iack) begin
            pc    <= Redirect ? RedirectPC : pend_pc;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // pc is also the outstanding address while in DROP, so Iaddr is simply pc.
  assign Iaddr     = pc;
  assign Ireq      = (state == REQ) || (state == DROP);
  assign InsValid  = (state == HOLD);
  assign Ins       = ins;
  assign InsPC     = ins_pc;
  assign InsPC4    = ins_pc4;
  assign fsm_state = state;

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch.
//
// A responder process models instruction memory with a programmable number
// of wait cycles. A transaction-level model tracks which address is on the
// bus and which word is on offer to decode. It is updated on each rising
// edge from that edge's inputs, and it is compared with the DUT on every
// falling edge. Directed phases add hand-computed literal checks.
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef IFETCH_PREDECODE_EN
  localparam bit PREDECODE = 1'b1;
`else
  localparam bit PREDECODE = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic [31:0] Iaddr;
  logic        Ireq;
  logic        Iack;
  logic [31:0] Irdata;
  logic [31:0] Ins;
  logic [31:0] InsPC;
  logic [31:0] InsPC4;
  logic        InsValid;
  logic        InsReady;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [1:0]  fsm_state;

  ifetch #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RST(RST), .Iaddr(Iaddr), .Ireq(Ireq), .Iack(Iack),
    .Irdata(Irdata), .Ins(Ins), .InsPC(InsPC), .InsPC4(InsPC4),
    .InsValid(InsValid), .InsReady(InsReady), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] special_word;
  int          mem_wait;
  int          wcnt;
  bit          force_ack;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return special_word;
    return {8'h20, a[23:0]} ^ 32'h0000_5A5A;  // opcode 6'h08, never a jump
  endfunction

  always @(negedge CLK) begin
    if (force_ack) begin
      Iack   = 1'b1;
      Irdata = 32'hDEAD_BEEF;
      wcnt   = 0;
    end else if (Ireq) begin
      if (wcnt >= mem_wait) begin
        Iack   = 1'b1;
        Irdata = mem_word(Iaddr);
        wcnt   = 0;
      end else begin
        Iack   = 1'b0;
        Irdata = 32'h0BAD_0BAD;
        wcnt   = wcnt + 1;
      end
    end else begin
      Iack   = 1'b0;
      Irdata = 32'h0BAD_0BAD;
      wcnt   = 0;
    end
  end

  // ---------------- transaction model ----------------
  bit          m_quiet;   // the one quiet cycle after reset
  bit          m_req;     // a read is on the bus
  bit          m_stale;   // that read belongs to a flushed stream
  bit          m_valid;   // a word is on offer to decode
  logic [31:0] m_addr;    // address on the bus while m_req
  logic [31:0] m_pend;    // where to go after the stale read completes
  logic [31:0] m_ins;
  logic [31:0] m_ipc;
  logic [31:0] m_next;    // program-order successor of the word on offer

  function automatic logic [31:0] succ(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (PREDECODE && (w[31:26] == 6'h02 || w[31:26] == 6'h03))
      return {p4[31:28], w[25:0], 2'b00};
    return p4;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_quiet = 1'b1; m_req = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
      m_addr  = RST_PC; m_pend = RST_PC; m_ins = 32'd0; m_ipc = 32'd0;
      m_next  = RST_PC;
    end else if (m_quiet) begin
      m_quiet = 1'b0;
      m_req   = 1'b1;
      if (Redirect) m_addr = RedirectPC;
    end else if (m_valid) begin
      if (Redirect) begin
        m_valid = 1'b0; m_req = 1'b1; m_addr = RedirectPC;
      end else if (InsReady) begin
        m_valid = 1'b0; m_req = 1'b1; m_addr = m_next;
      end
    end else if (m_req) begin
      if (m_stale) begin
        if (Iack) begin
          m_stale = 1'b0;
          m_addr  = Redirect ? RedirectPC : m_pend;
        end else if (Redirect) begin
          m_pend = RedirectPC;
        end
      end else if (Iack) begin
        if (Redirect) begin
          m_addr = RedirectPC;
        end else begin
          m_valid = 1'b1; m_req = 1'b0;
          m_ins = Irdata; m_ipc = m_addr; m_next = succ(m_addr, Irdata);
        end
      end else if (Redirect) begin
        m_stale = 1'b1; m_pend = RedirectPC;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge CLK) begin
    if (RST) begin
      check("ireq", {31'd0, Ireq}, {31'd0, m_req});
      check("insvalid", {31'd0, InsValid}, {31'd0, m_valid});
      if (m_req) check("iaddr", Iaddr, m_addr);
      if (m_valid) begin
        check("ins", Ins, m_ins);
        check("inspc", InsPC, m_ipc);
        check("inspc4", InsPC4, m_ipc + 32'd4);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!InsValid && k < 40) begin
      tick();
      k++;
    end
    check("valid_timeout", {31'd0, InsValid}, 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_ireq", {31'd0, Ireq}, 32'd0);
    check("rst_iaddr", Iaddr, RST_PC);
    check("rst_ins", Ins, 32'd0);
    check("rst_inspc", InsPC, 32'd0);
    check("rst_inspc4", InsPC4, 32'd4);
    check("rst_insvalid", {31'd0, InsValid}, 32'd0);
  endtask

  initial begin
    RST = 1'b0; InsReady = 1'b0; Redirect = 1'b0; RedirectPC = 32'd0;
    Iack = 1'b0; Irdata = 32'd0; wcnt = 0; force_ack = 1'b0;
    mem_wait = 0; special_word = 32'h2008_0005;

    // Reset release, zero-wait memory
    repeat (3) tick();
    check_reset_values();
    RST = 1'b1;
    tick();
    check("first_ireq", {31'd0, Ireq}, 32'd1);
    check("first_iaddr", Iaddr, 32'h0040_0000);
    tick();
    check("first_valid", {31'd0, InsValid}, 32'd1);
    check("first_ins", Ins, 32'h2008_0005);
    check("first_inspc4", InsPC4, 32'h0040_0004);

    // Decode backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, InsValid}, 32'd1);
      check("bp_ins", Ins, 32'h2008_0005);
      check("bp_ireq", {31'd0, Ireq}, 32'd0);
    end
    InsReady = 1'b1;
    tick();
    InsReady = 1'b0;
    check("bp_next_iaddr", Iaddr, 32'h0040_0004);
    check("bp_next_ireq", {31'd0, Ireq}, 32'd1);
    tick();
    check("bp_second_pc", InsPC, 32'h0040_0004);

    // Three wait cycles, redirect in the first REQ cycle
    mem_wait = 3;
    InsReady = 1'b1;
    tick();
    InsReady = 1'b0;
    Redirect = 1'b1; RedirectPC = 32'h0000_0100;
    tick();
    Redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drop_ireq", {31'd0, Ireq}, 32'd1);
      check("drop_iaddr", Iaddr, 32'h0040_0008);
      check("drop_novalid", {31'd0, InsValid}, 32'd0);
      tick();
    end
    check("drop_new_iaddr", Iaddr, 32'h0000_0100);
    check("drop_new_valid", {31'd0, InsValid}, 32'd0);
    wait_valid();
    check("drop_target_pc", InsPC, 32'h0000_0100);
    check("drop_target_ins", Ins, 32'h2000_5B5A);

    // Redirect together with InsReady in HOLD
    mem_wait = 0;
    Redirect = 1'b1; RedirectPC = 32'h0000_0200; InsReady = 1'b1;
    tick();
    Redirect = 1'b0; InsReady = 1'b0;
    check("hold_redir_valid", {31'd0, InsValid}, 32'd0);
    check("hold_redir_iaddr", Iaddr, 32'h0000_0200);
    tick();
    check("hold_redir_pc", InsPC, 32'h0000_0200);

    // PC wrap
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    tick();
    Redirect = 1'b0;
    check("wrap_iaddr", Iaddr, 32'hFFFF_FFFC);
    tick();
    check("wrap_inspc4", InsPC4, 32'h0000_0000);
    InsReady = 1'b1;
    tick();
    InsReady = 1'b0;
    check("wrap_next_iaddr", Iaddr, 32'h0000_0000);
    tick();

    // Redirect in REQ together with Iack
    InsReady = 1'b1;
    tick();
    InsReady = 1'b0;
    Redirect = 1'b1; RedirectPC = 32'h0000_0300;
    tick();
    Redirect = 1'b0;
    check("reqack_iaddr", Iaddr, 32'h0000_0300);
    check("reqack_novalid", {31'd0, InsValid}, 32'd0);
    tick();
    check("reqack_pc", InsPC, 32'h0000_0300);

    // Two redirects, the second together with the stale ack
    mem_wait = 1;
    InsReady = 1'b1;
    tick();
    InsReady = 1'b0;
    Redirect = 1'b1; RedirectPC = 32'h0000_0500;
    tick();
    RedirectPC = 32'h0000_0600;
    tick();
    Redirect = 1'b0;
    check("newest_iaddr", Iaddr, 32'h0000_0600);
    wait_valid();
    check("newest_pc", InsPC, 32'h0000_0600);

    // Jump predecode
    mem_wait = 0; special_word = 32'h0C00_0040;
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    check("jal_iaddr", Iaddr, 32'h0040_0000);
    tick();
    check("jal_ins", Ins, 32'h0C00_0040);
    check("jal_inspc4", InsPC4, 32'h0040_0004);
    InsReady = 1'b1;
    tick();
    InsReady = 1'b0;
    check("jal_next_iaddr", Iaddr, PREDECODE ? 32'h0000_0100 : 32'h0040_0004);
    wait_valid();

    // Async reset while in DROP
    mem_wait = 5;
    InsReady = 1'b1;
    tick();
    InsReady = 1'b0;
    Redirect = 1'b1; RedirectPC = 32'h0000_0700;
    tick();
    Redirect = 1'b0;
    check("pre_rst_ireq", {31'd0, Ireq}, 32'd1);
    #2 RST = 1'b0;
    force_ack = 1'b1;
    #1 check_reset_values();
    tick();
    tick();
    check_reset_values();
    #2 force_ack = 1'b0;
    mem_wait = 0;
    tick();
    RST = 1'b1;
    tick();
    check("post_rst_ireq", {31'd0, Ireq}, 32'd1);
    check("post_rst_iaddr", Iaddr, 32'h0040_0000);
    check("post_rst_novalid", {31'd0, InsValid}, 32'd0);
    tick();
    check("post_rst_ins", Ins, 32'h0C00_0040);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
